// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// iteration counter width and the saturated quotient value.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

    localparam logic [DIV_WIDTH-1:0] SAT_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {R,Q} left, trial-subtract
// the divisor, keep the difference and set the quotient bit when it is non-negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;

    // R < divisor holds between steps, so W+1 bits are enough and the MSB is the sign.
    assign r_sh  = {r_in[WIDTH-1:0], q_in[WIDTH-1]};
    assign trial = r_sh - {1'b0, divisor};

    assign r_out = trial[WIDTH] ? r_sh : trial;
    assign q_out = {q_in[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_32x16.sv
// Sequential 2W/W unsigned restoring divider with valid/ready handshakes,
// one quotient bit per cycle, divide-by-zero and overflow short-cuts.
module div_32x16
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     r_p0;
    logic [WIDTH-1:0]   q_p0;
    logic [WIDTH-1:0]   d_p0;
    logic [WIDTH:0]     r_nx;
    logic [WIDTH-1:0]   q_nx;
    logic               last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in    (r_p0),
        .q_in    (q_p0),
        .divisor (d_p0),
        .r_out   (r_nx),
        .q_out   (q_nx)
    );

    assign in_ready  = (state == IDLE) && !rst;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            r_p0        <= '0;
            q_p0        <= '0;
            d_p0        <= '0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_p0        <= divisor;
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= SAT_ONES;
                            remainder   <= dividend[WIDTH-1:0];
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                            quotient  <= SAT_ONES;
                            remainder <= '0;
                            overflow  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            r_p0  <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
                            q_p0  <= dividend[WIDTH-1:0];
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_p0 <= r_nx;
                    q_p0 <= q_nx;
                    cnt  <= cnt + 1'b1;
                    if (last_step) begin
                        quotient  <= q_nx;
                        remainder <= r_nx[WIDTH-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Results hold; new operands are only taken back in IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
